// File: rtl/combine_initiator.sv
// Start/done combine-unit initiator: queues operand requests, runs one responder transaction at a time,
// returns the captured result on a held valid/ready port. Optional COMBINE_INIT_STATS_EN adds issue/timeout counters.

module combine_initiator_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdat_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module combine_initiator #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_mode_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [WIDTH-1:0] req_c_i,
  input  logic [WIDTH-1:0] req_d_i,
  output logic             start_o,
  output logic             mode_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] d_o,
  output logic             core_rst_o,
  input  logic [WIDTH-1:0] result_i,
  input  logic             done_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_error_o,
  output logic             busy_o
`ifdef COMBINE_INIT_STATS_EN
  ,
  output logic [15:0]      issued_cnt_o,
  output logic [15:0]      timeout_cnt_o
`endif
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RECOVER
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic             start_q;
  logic             mode_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic             core_rst_q;
  logic             timed_out_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_error_q;

  req_t             push_d;
  req_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             wait_timeout;

  assign push_d    = '{mode: req_mode_i, a: req_a_i, b: req_b_i, c: req_c_i, d: req_d_i};
  assign req_ready_o = reset_ni & ~fifo_full;
  assign fifo_push = req_valid_i & req_ready_o;
  // A held response must be accepted (or be accepted this edge) before the next issue.
  assign fifo_pop  = (state_q == S_IDLE) & ~fifo_empty & (~rsp_valid_q | rsp_ready_i);
  assign wait_timeout = (state_q == S_WAIT) & ~done_i & (timer_q == TW'(TIMEOUT - 1));

  combine_initiator_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .push_i   (fifo_push),
    .wdat_i   (push_d),
    .pop_i    (fifo_pop),
    .rdat_o   (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      start_q     <= 1'b0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      core_rst_q  <= 1'b0;
      timed_out_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (fifo_pop) begin
            mode_q  <= head.mode;
            a_q     <= head.a;
            b_q     <= head.b;
            c_q     <= head.c;
            d_q     <= head.d;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b1;
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (timer_q != TW'(TIMEOUT)) begin
            timer_q <= timer_q + 1'b1;
          end
          // done has priority over a timeout landing on the same cycle.
          if (done_i) begin
            start_q     <= 1'b0;
            timed_out_q <= 1'b0;
            state_q     <= S_CAPTURE;
          end else if (wait_timeout) begin
            start_q     <= 1'b0;
            timed_out_q <= 1'b1;
            state_q     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          rsp_data_q  <= result_i;
          rsp_error_q <= timed_out_q;
          rsp_valid_q <= 1'b1;
          core_rst_q  <= 1'b1;
          state_q     <= S_RECOVER;
        end
        S_RECOVER: begin
          core_rst_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef COMBINE_INIT_STATS_EN
  logic [15:0] issued_cnt_q;
  logic [15:0] timeout_cnt_q;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      issued_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if ((state_q == S_ISSUE) && (issued_cnt_q != 16'hFFFF)) begin
        issued_cnt_q <= issued_cnt_q + 16'd1;
      end
      if (wait_timeout && (timeout_cnt_q != 16'hFFFF)) begin
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end
    end
  end

  assign issued_cnt_o  = issued_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
`endif

  assign start_o     = start_q;
  assign mode_o      = mode_q;
  assign a_o         = a_q;
  assign b_o         = b_q;
  assign c_o         = c_q;
  assign d_o         = d_q;
  assign core_rst_o  = core_rst_q | ~reset_ni;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_error_o = rsp_error_q;
  assign busy_o      = (state_q != S_IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_combine_initiator.sv
// Scoreboard bench for combine_initiator with a delay-programmable responder model.
module tb_combine_initiator;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 255;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_mode = 1'b0;
  logic [7:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic       start, mode;
  logic [7:0] a, b, c, d;
  logic       core_rst;
  logic [7:0] result;
  logic       done = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_error;
  logic       busy;
`ifdef COMBINE_INIT_STATS_EN
  logic [15:0] issued_cnt, timeout_cnt;
`endif

  always #5 clock = ~clock;

  combine_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clock), .reset_ni(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_mode_i(req_mode),
    .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c), .req_d_i(req_d),
    .start_o(start), .mode_o(mode), .a_o(a), .b_o(b), .c_o(c), .d_o(d),
    .core_rst_o(core_rst), .result_i(result), .done_i(done),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_error_o(rsp_error), .busy_o(busy)
`ifdef COMBINE_INIT_STATS_EN
    , .issued_cnt_o(issued_cnt), .timeout_cnt_o(timeout_cnt)
`endif
  );

  typedef struct {
    int data;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   dly_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   cur_dly = NEVER;
  int   rsp_cnt = 0;
  int   start_rises = 0;
  int   rdy_mode = 1;
  int   rcnt = 0;

  function automatic int model(input logic m, input int ia, input int ib, input int ic, input int id);
    int s;
    s = m ? (ia - ib + ic - id) : (ia + ib + ic + id);
    return s & 255;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: done rises cur_dly cycles after start rises, cleared by core_rst.
  assign result = mode ? (a - b + c - d) : (a + b + c + d);
  always @(posedge clock) begin
    if (core_rst) begin
      done <= 1'b0;
      rcnt <= 0;
    end else if (start && !done) begin
      rcnt <= rcnt + 1;
      if (rcnt + 1 == cur_dly) done <= 1'b1;
    end
  end

  initial forever begin
    @(posedge clock); #1;
    rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
  end

  // Monitor: start pulse length, core_rst pulse length, response scoreboard.
  initial begin
    exp_t e;
    int slen, clen;
    slen = 0;
    clen = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        slen = 0;
        clen = 0;
      end else begin
        if (start) begin
          if (slen == 0) begin
            start_rises++;
            if (dly_q.size() == 0) begin
              check("unexpected_start", 1, 0);
              cur_dly = NEVER;
            end else begin
              cur_dly = dly_q.pop_front();
            end
          end
          slen++;
        end else if (slen > 0) begin
          check("start_len", slen, (cur_dly + 1 > TIMEOUT) ? TIMEOUT : cur_dly + 1);
          slen = 0;
        end
        if (core_rst) clen++;
        else if (clen > 0) begin
          check("core_rst_len", clen, 1);
          clen = 0;
        end
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rsp_data", int'(rsp_data), e.data);
            check("rsp_error", int'(rsp_error), e.err);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send(input logic m, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ic, input logic [7:0] id, input int dly);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    req_valid = 1'b1;
    req_mode = m; req_a = ia; req_b = ib; req_c = ic; req_d = id;
    forever begin
      @(negedge clock);
      acc = req_ready;
      @(posedge clock); #1;
      if (acc) break;
      guard++;
      if (guard > 500) begin
        check("req_accept_timeout", 0, 1);
        break;
      end
    end
    if (acc) begin
      exp_q.push_back('{model(m, ia, ib, ic, id), (dly + 1 > TIMEOUT) ? 1 : 0});
      dly_q.push_back(dly);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 4000) begin
      cyc(1);
      guard++;
    end
    if (guard >= 4000) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rises, d;
    cyc(3);
    check("rst_start", start, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_a", a, 0);
    reset_n = 1'b1;
    cyc(1);
    check("rel_core_rst", core_rst, 0);
    check("rel_req_ready", req_ready, 1);

    // 1: mode 0 wraps to 00; push-to-start latency is two edges.
    rdy_mode = 1;
    send(1'b0, 8'h01, 8'h02, 8'hFF, 8'hFE, 3);
    cyc(1);
    check("lat_start_early", start, 0);
    cyc(1);
    check("lat_start", start, 1);
    wait_drain();

    // 2: mode 1
    send(1'b1, 8'hFE, 8'h01, 8'h01, 8'h04, 3);
    wait_drain();

    // 3: five requests with downstream stalled
    rdy_mode = 0;
    cyc(2);
    rises = start_rises;
    for (int i = 0; i < 5; i++) send(1'(i), 8'(i * 17), 8'(i + 3), 8'h40, 8'(i), 3);
    cyc(20);
    check("full_req_ready", req_ready, 0);
    check("stalled_starts", start_rises - rises, 1);
    check("stalled_rsp_valid", rsp_valid, 1);
    rdy_mode = 1;
    wait_drain();

    // 4: responder never answers
    send(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, NEVER);
    wait_drain();
`ifdef COMBINE_INIT_STATS_EN
    check("timeout_cnt", timeout_cnt, 1);
    check("issued_cnt", issued_cnt, 8);
`endif

    // 5: reset while waiting
    send(1'b0, 8'h05, 8'h06, 8'h07, 8'h08, NEVER);
    cyc(5);
    check("pre_rst_start", start, 1);
    reset_n = 1'b0;
    cyc(1);
    check("mid_rst_start", start, 0);
    check("mid_rst_core_rst", core_rst, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    dly_q.delete();
    base = rsp_cnt;
    cyc(2);
    reset_n = 1'b1;
    cyc(20);
    check("no_rsp_after_rst", rsp_cnt - base, 0);
`ifdef COMBINE_INIT_STATS_EN
    check("stats_cleared", timeout_cnt, 0);
`endif

    // 6: done on the timeout cycle wins; one cycle later it is a timeout
    send(1'b1, 8'h80, 8'h10, 8'h05, 8'h01, TIMEOUT - 1);
    send(1'b0, 8'h80, 8'h10, 8'h05, 8'h01, TIMEOUT);
    wait_drain();

    // Random traffic with random backpressure
    rdy_mode = 2;
    base = rsp_cnt;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 15))
        12:      d = TIMEOUT - 1;
        13:      d = TIMEOUT;
        14:      d = NEVER;
        default: d = 1 + int'($urandom_range(0, 4));
      endcase
      send(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), d);
      cyc(int'($urandom_range(0, 2)));
    end
    wait_drain();
    check("rand_rsp_count", rsp_cnt - base, 150);
    check("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
